camara_tx: RTL and testbench

CAMARA_TX -- requirements
Module: camara_tx

---
 rtl/camara_tx.sv | 210 +++++++++++++++++++++
 tb/tb_camara_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/camara_tx.sv
// OV7670-style camera transmitter: Pclk=clk/2, Vsync/Href framing, RGB565 bytes (optional test patterns via CAMARA_TX_PATTERN_EN).
// Outputs are registered and change only on the clk edge where Pclk falls; PWDN or Reset abort a frame immediately.
module camara_tx #(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_LEN = 3,
  parameter int V_BACK    = 17,
  parameter int V_FRONT   = 10
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        En,
  input  logic        PWDN,
  input  logic [15:0] Color,
`ifdef CAMARA_TX_PATTERN_EN
  input  logic [1:0]  Patron,
`endif
  output logic        Pclk,
  output logic        Vsync,
  output logic        Href,
  output logic [7:0]  Imagen,
  output logic        Frame_done,
  output logic        Busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VSYNC  = 3'd1;
  localparam logic [2:0] VBACK  = 3'd2;
  localparam logic [2:0] ACTIVE = 3'd3;
  localparam logic [2:0] HBLANK = 3'd4;
  localparam logic [2:0] VFRONT = 3'd5;

  localparam int L     = 2 * H_ACT + H_BLANK;
  localparam int R_VS  = VSYNC_LEN * L;
  localparam int R_VB  = V_BACK * L;
  localparam int R_VF  = V_FRONT * L;
  localparam int R_M1  = (R_VS > R_VB) ? R_VS : R_VB;
  localparam int R_M2  = (R_M1 > R_VF) ? R_M1 : R_VF;
  localparam int R_MAX = (R_M2 > H_BLANK) ? R_M2 : H_BLANK;
  localparam int CW    = $clog2(R_MAX + 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [10:0]   x, y;
  logic          bsel;
  logic [15:0]   pix;
  logic          cnt_last;

  assign Busy = (state != IDLE);

  always_comb begin
    cnt_last = 1'b0;
    case (state)
      VSYNC:   cnt_last = (cnt == CW'(R_VS - 1));
      VBACK:   cnt_last = (cnt == CW'(R_VB - 1));
      HBLANK:  cnt_last = (cnt == CW'(H_BLANK - 1));
      VFRONT:  cnt_last = (cnt == CW'(R_VF - 1));
      default: cnt_last = 1'b0;
    endcase
  end

`ifdef CAMARA_TX_PATTERN_EN
  localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
  logic [1:0]  pat;
  logic [10:0] pix_x, pix_y, bar_q;
  logic [2:0]  bar;

  // Coordinates of the pixel whose byte is emitted on the coming tick.
  always_comb begin
    pix_x = 11'd0;
    pix_y = y;
    if (state == ACTIVE) pix_x = bsel ? x + 11'd1 : x;
    if (state == HBLANK) pix_y = y + 11'd1;
    bar_q = pix_x / 11'(BAR_W);
    bar   = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];
    pix   = Color;
    case (pat)
      2'd1: begin
        case (bar)
          3'd0: pix = 16'hFFFF;
          3'd1: pix = 16'hFFE0;
          3'd2: pix = 16'h07FF;
          3'd3: pix = 16'h07E0;
          3'd4: pix = 16'hF81F;
          3'd5: pix = 16'hF800;
          3'd6: pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd2:    pix = {5'b0, pix_x[5:0], 5'b0};
      2'd3:    pix = (pix_x[3] ^ pix_y[3]) ? 16'hFFFF : 16'h0000;
      default: pix = Color;
    endcase
  end
`else
  assign pix = Color;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      x          <= '0;
      y          <= '0;
      bsel       <= 1'b0;
      Pclk       <= 1'b0;
      Vsync      <= 1'b0;
      Href       <= 1'b0;
      Imagen     <= 8'h00;
      Frame_done <= 1'b0;
`ifdef CAMARA_TX_PATTERN_EN
      pat        <= 2'd0;
`endif
    end else if (PWDN) begin
      state      <= IDLE;
      cnt        <= '0;
      x          <= '0;
      y          <= '0;
      bsel       <= 1'b0;
      Pclk       <= 1'b0;
      Vsync      <= 1'b0;
      Href       <= 1'b0;
      Imagen     <= 8'h00;
      Frame_done <= 1'b0;
    end else begin
      Pclk       <= ~Pclk;
      Frame_done <= 1'b0;
      if (Pclk) begin
        case (state)
          IDLE: begin
            if (En) begin
              state <= VSYNC;
              Vsync <= 1'b1;
              cnt   <= '0;
`ifdef CAMARA_TX_PATTERN_EN
              pat   <= Patron;
`endif
            end
          end
          VSYNC: begin
            if (cnt_last) begin
              state <= VBACK;
              Vsync <= 1'b0;
              cnt   <= '0;
            end else cnt <= cnt + 1'b1;
          end
          VBACK: begin
            if (cnt_last) begin
              state  <= ACTIVE;
              Href   <= 1'b1;
              Imagen <= pix[15:8];
              x      <= '0;
              y      <= '0;
              bsel   <= 1'b0;
              cnt    <= '0;
            end else cnt <= cnt + 1'b1;
          end
          ACTIVE: begin
            if (!bsel) begin
              Imagen <= pix[7:0];
              bsel   <= 1'b1;
            end else if (x == 11'(H_ACT - 1)) begin
              state  <= HBLANK;
              Href   <= 1'b0;
              Imagen <= 8'h00;
              x      <= '0;
              bsel   <= 1'b0;
              cnt    <= '0;
            end else begin
              x      <= x + 11'd1;
              Imagen <= pix[15:8];
              bsel   <= 1'b0;
            end
          end
          HBLANK: begin
            if (cnt_last) begin
              cnt <= '0;
              if (y == 11'(V_ACT - 1)) begin
                y     <= '0;
                state <= VFRONT;
              end else begin
                y      <= y + 11'd1;
                state  <= ACTIVE;
                Href   <= 1'b1;
                Imagen <= pix[15:8];
                bsel   <= 1'b0;
              end
            end else cnt <= cnt + 1'b1;
          end
          VFRONT: begin
            if (cnt_last) begin
              Frame_done <= 1'b1;
              cnt        <= '0;
              if (En) begin
                state <= VSYNC;
                Vsync <= 1'b1;
`ifdef CAMARA_TX_PATTERN_EN
                pat   <= Patron;
`endif
              end else state <= IDLE;
            end else cnt <= cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_camara_tx.sv
// Bench for camara_tx: frames are checked tick by tick against a line/pixel model of the output timing.
module tb_camara_tx;
  localparam int H_ACT = 4, V_ACT = 2, H_BLANK = 2, VSYNC_LEN = 1, V_BACK = 1, V_FRONT = 1;
  localparam int L = 2 * H_ACT + H_BLANK;
  localparam int FRAME = (VSYNC_LEN + V_BACK + V_ACT + V_FRONT) * L;

  logic clk = 1'b0;
  logic Reset, En, PWDN;
  logic [15:0] Color;
`ifdef CAMARA_TX_PATTERN_EN
  logic [1:0] Patron;
`endif
  logic Pclk, Vsync, Href, Frame_done, Busy;
  logic [7:0] Imagen;

  int checks = 0;
  int errors = 0;

  camara_tx #(.H_ACT(H_ACT), .V_ACT(V_ACT), .H_BLANK(H_BLANK),
              .VSYNC_LEN(VSYNC_LEN), .V_BACK(V_BACK), .V_FRONT(V_FRONT)) dut (
    .clk(clk), .Reset(Reset), .En(En), .PWDN(PWDN), .Color(Color),
`ifdef CAMARA_TX_PATTERN_EN
    .Patron(Patron),
`endif
    .Pclk(Pclk), .Vsync(Vsync), .Href(Href), .Imagen(Imagen),
    .Frame_done(Frame_done), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_pix(input int px, input int py, input int pat, input logic [15:0] c);
    logic [10:0] xv, yv;
    int bw, bar;
    xv = 11'(px);
    yv = 11'(py);
    bw = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
    bar = px / bw;
    if (bar > 7) bar = 7;
    case (pat)
      1: case (bar)
           0: return 16'hFFFF;
           1: return 16'hFFE0;
           2: return 16'h07FF;
           3: return 16'h07E0;
           4: return 16'hF81F;
           5: return 16'hF800;
           6: return 16'h001F;
           default: return 16'h0000;
         endcase
      2: return {5'b0, xv[5:0], 5'b0};
      3: return (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
      default: return c;
    endcase
  endfunction

  // Expected outputs during tick k of a frame (k=0 is the Vsync entry tick).
  task automatic exp_at(input int k, input logic [15:0] c, input int pat,
                        output logic vs, output logic hr, output logic [7:0] im);
    int line, pos, a;
    logic [15:0] p;
    line = k / L;
    pos  = k % L;
    a    = line - VSYNC_LEN - V_BACK;
    vs   = (line < VSYNC_LEN);
    hr   = (a >= 0) && (a < V_ACT) && (pos < 2 * H_ACT);
    p    = ref_pix(pos / 2, a, pat, c);
    im   = hr ? ((pos % 2) ? p[7:0] : p[15:8]) : 8'h00;
  endtask

  task automatic wait_vsync();
    int n;
    n = 0;
    while (Vsync !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("vsync_start", Vsync, 1'b1);
  endtask

  // Starts at the sample point just after the Vsync entry tick; ends at the one after the frame's last tick.
  task automatic run_frame(input logic [15:0] c, input int drop_at, input logic fd0, input logic en_end);
    logic vs, hr;
    logic [7:0] im;
    int pat;
    pat = 0;
`ifdef CAMARA_TX_PATTERN_EN
    pat = int'(Patron);
`endif
    for (int k = 0; k < FRAME; k++) begin
      exp_at(k, c, pat, vs, hr, im);
      chk("vsync", Vsync, vs);
      chk("href", Href, hr);
      chk("imagen", Imagen, im);
      chk("frame_done_tick", Frame_done, (k == 0) ? fd0 : 1'b0);
      chk("pclk_lo", Pclk, 1'b0);
      chk("busy", Busy, 1'b1);
`ifdef CAMARA_TX_PATTERN_EN
      if (k == 5) Patron = 2'($urandom_range(0, 3));
`endif
      if (k == drop_at) En = 1'b0;
      @(negedge clk);
      chk("pclk_hi", Pclk, 1'b1);
      chk("frame_done_mid", Frame_done, 1'b0);
      @(negedge clk);
    end
    chk("frame_done_end", Frame_done, 1'b1);
    chk("vsync_next", Vsync, en_end);
    chk("busy_next", Busy, en_end);
    chk("href_end", Href, 1'b0);
  endtask

  initial begin
    Reset = 1'b0;
    En    = 1'b0;
    PWDN  = 1'b0;
    Color = 16'($urandom);
`ifdef CAMARA_TX_PATTERN_EN
    Patron = 2'd1;
`endif
    #12;
    chk("rst_pclk", Pclk, 1'b0);
    chk("rst_vsync", Vsync, 1'b0);
    chk("rst_href", Href, 1'b0);
    chk("rst_imagen", Imagen, 8'h00);
    chk("rst_fd", Frame_done, 1'b0);
    chk("rst_busy", Busy, 1'b0);

    @(negedge clk);
    Reset = 1'b1;
    En    = 1'b1;
    wait_vsync();
    run_frame(Color, -1, 1'b0, 1'b1);

    Color = 16'hF81F;
    run_frame(Color, -1, 1'b1, 1'b1);

    Color = 16'($urandom);
    run_frame(Color, 20 + int'($urandom_range(0, 9)), 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("idle_vsync", Vsync, 1'b0);
      chk("idle_busy", Busy, 1'b0);
      chk("idle_fd", Frame_done, 1'b0);
    end

    En = 1'b1;
    Color = 16'($urandom);
    wait_vsync();
    repeat (44) @(negedge clk);
    chk("pre_pwdn_href", Href, 1'b1);
    PWDN = 1'b1;
    @(negedge clk);
    chk("pwdn_pclk", Pclk, 1'b0);
    chk("pwdn_vsync", Vsync, 1'b0);
    chk("pwdn_href", Href, 1'b0);
    chk("pwdn_imagen", Imagen, 8'h00);
    chk("pwdn_busy", Busy, 1'b0);
    chk("pwdn_fd", Frame_done, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("pwdn_hold_fd", Frame_done, 1'b0);
      chk("pwdn_hold_pclk", Pclk, 1'b0);
    end
    PWDN = 1'b0;
    wait_vsync();
    run_frame(Color, -1, 1'b0, 1'b1);

    repeat (30) @(negedge clk);
    chk("vback_vsync", Vsync, 1'b0);
    chk("vback_busy", Busy, 1'b1);
    #1 Reset = 1'b0;
    #1;
    chk("arst_pclk", Pclk, 1'b0);
    chk("arst_vsync", Vsync, 1'b0);
    chk("arst_href", Href, 1'b0);
    chk("arst_imagen", Imagen, 8'h00);
    chk("arst_busy", Busy, 1'b0);
    chk("arst_fd", Frame_done, 1'b0);
    @(negedge clk);
    Reset = 1'b1;
    Color = 16'($urandom);
    wait_vsync();
    run_frame(Color, -1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
